// File: rtl/brent_kung_pkg.sv
// Shared types and helpers for the sequential Brent-Kung prefix/sum block.
package brent_kung_pkg;

    typedef enum logic [2:0] {IDLE, UP, DOWN, SUM, DONE} state_t;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // hi o lo: the higher-column group absorbs the lower one
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t result;
        result.g = hi.g | (hi.p & lo.g);
        result.p = hi.p & lo.p;
        return result;
    endfunction

endpackage

// File: rtl/pg_black_cell.sv
// Combinational group propagate/generate combine cell.
module pg_black_cell
    import brent_kung_pkg::*;
(
    input  pg_t i_hi,
    input  pg_t i_lo,
    output pg_t o_out
);

    assign o_out = pg_combine(i_hi, i_lo);

endmodule

// File: rtl/pg_prefix_sum_seq.sv
// Multi-cycle Brent-Kung prefix tree: one tree level per clock, then a sum
// cycle, with the result held behind a valid/ready handshake.
module pg_prefix_sum_seq
    import brent_kung_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH:0]   P_IN,
    input  logic [WIDTH:0]   G_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             C_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int L  = clog2(WIDTH);
    localparam int KW = clog2(L + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_gw;
    logic [WIDTH-1:0] r_pw;
    logic [WIDTH-1:0] r_p_cap;
    logic             r_gt;
    logic             r_pt;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_en;
    logic [WIDTH-1:0] w_upd_g;
    logic [WIDTH-1:0] w_upd_p;

    // Column 0 never changes; it already holds the carry-in group.
    assign w_en[0]    = 1'b0;
    assign w_upd_g[0] = r_gw[0];
    assign w_upd_p[0] = r_pw[0];

    genvar gi, gl;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_col
            logic [L:1] w_lo_g;
            logic [L:1] w_lo_p;
            logic [L:1] w_lvl_en;
            pg_t        w_hi;
            pg_t        w_lo;
            pg_t        w_comb;

            for (gl = 1; gl <= L; gl++) begin : g_lvl
                localparam int OFF    = 1 << (gl - 1);
                localparam bit UP_HIT = ((gi % (1 << gl)) == ((1 << gl) - 1));
                localparam bit DN_HIT = (gl < L) && (gi >= (1 << gl)) &&
                                        ((gi % (1 << gl)) == (OFF - 1));
                logic w_sel;

                assign w_sel = (r_k == KW'(gl));
                if (gi >= OFF) begin : g_src
                    assign w_lo_g[gl] = w_sel & r_gw[gi-OFF];
                    assign w_lo_p[gl] = w_sel & r_pw[gi-OFF];
                end else begin : g_nosrc
                    assign w_lo_g[gl] = 1'b0;
                    assign w_lo_p[gl] = 1'b0;
                end
                assign w_lvl_en[gl] = w_sel & (((r_state == UP)   && UP_HIT) ||
                                               ((r_state == DOWN) && DN_HIT));
            end

            assign w_hi = '{g: r_gw[gi], p: r_pw[gi]};
            assign w_lo = '{g: |w_lo_g, p: |w_lo_p};

            pg_black_cell u_cell (
                .i_hi  (w_hi),
                .i_lo  (w_lo),
                .o_out (w_comb)
            );

            assign w_en[gi]    = |w_lvl_en;
            assign w_upd_g[gi] = w_comb.g;
            assign w_upd_p[gi] = w_comb.p;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_gw        <= '0;
            r_pw        <= '0;
            r_p_cap     <= '0;
            r_gt        <= 1'b0;
            r_pt        <= 1'b0;
            r_s         <= '0;
            r_c_out     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_gw    <= G_IN[WIDTH-1:0];
                        r_pw    <= P_IN[WIDTH-1:0];
                        r_p_cap <= P_IN[WIDTH:1];
                        r_gt    <= G_IN[WIDTH];
                        r_pt    <= P_IN[WIDTH];
                        r_k     <= KW'(1);
                    end
                end
                UP, DOWN: begin
                    r_gw <= (r_gw & ~w_en) | (w_upd_g & w_en);
                    r_pw <= (r_pw & ~w_en) | (w_upd_p & w_en);
                    if (r_state == DOWN) begin
                        r_k <= r_k - 1'b1;
                    end else if (r_k == KW'(L)) begin
                        r_k <= KW'(L - 1);
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                SUM: begin
                    r_s         <= r_p_cap ^ r_gw;
                    r_c_out     <= r_gt | (r_pt & r_gw[WIDTH-1]);
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (IN_VALID) w_state_next = UP;
            UP:      if (r_k == KW'(L)) w_state_next = (L == 1) ? SUM : DOWN;
            DOWN:    if (r_k == KW'(1)) w_state_next = SUM;
            SUM:     w_state_next = DONE;
            DONE:    if (OUT_READY) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        IN_READY = (r_state == IDLE);
    end

    assign S         = r_s;
    assign C_OUT     = r_c_out;
    assign OUT_VALID = r_out_valid;

endmodule

// File: doc/pg_prefix_sum_seq.md
# pg_prefix_sum_seq

Sequential consumer of the bitwise PG stage in the Brent-Kung adder path. It accepts one column-indexed propagate/generate vector, with column 0 carrying the carry-in. It evaluates the Brent-Kung prefix tree one level per clock, then produces the sum word and carry-out behind a valid/ready handshake. It is the area-lean, multi-cycle alternative to the fully combinational prefix and sum network.

## Interface
Parameters:
- WIDTH, 8, adder width in bits. Must be a power of two and at least 2. L = log2(WIDTH).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- P_IN  in  WIDTH+1  propagate per column; bit i = P_i. Bit 0 must be 0.
- G_IN  in  WIDTH+1  generate per column; bit i = G_i. Bit 0 is the carry-in C_0.
- IN_VALID  in  1  P_IN/G_IN hold a valid operand.
- IN_READY  out  1  block can accept an operand; high only in IDLE.
- S  out  WIDTH  sum; S[j] is the sum of column j+1.
- C_OUT  out  1  carry out of column WIDTH.
- OUT_VALID  out  1  S/C_OUT hold a valid result.
- OUT_READY  in  1  downstream accepts the result.

## Operation
- Combine operator (hi∘lo):
  - G = G_hi | (P_hi & G_lo).
  - P = P_hi & P_lo.
- Working registers gw/pw[0..WIDTH-1] hold P_IN/G_IN bits 0..WIDTH-1. Column WIDTH is held separately as gt/pt.
- IDLE: IN_READY=1. On IN_VALID&IN_READY, capture all WIDTH+1 columns, set k=1, go to UP.
- UP, levels k=1..L, one per cycle:
  - Every i with i mod 2^k = 2^k−1 becomes w[i] ∘ w[i−2^(k−1)].
  - After k=L: if L=1 go to SUM; otherwise set k=L−1 and go to DOWN.
- DOWN, levels k=L−1..1, one per cycle:
  - Every i with i ≥ 2^k and i mod 2^k = 2^(k−1)−1 becomes w[i] ∘ w[i−2^(k−1)].
  - After k=1, go to SUM.
  - Afterwards gw[i] = G[i:0] for all i < WIDTH.
- SUM, one cycle:
  - S[j] = P_IN-captured P_(j+1) xor gw[j].
  - C_OUT = gt | (pt & gw[WIDTH−1]).
  - Set OUT_VALID and go to DONE.
- DONE:
  - Hold S, C_OUT and OUT_VALID stable while OUT_READY=0.
  - On OUT_READY=1, clear OUT_VALID at the next edge and go to IDLE.
- Level schedule for WIDTH=8:
  - UP k=1: pairs 1←0, 3←2, 5←4, 7←6.
  - UP k=2: pairs 3←1, 7←5.
  - UP k=3: pair 7←3.
  - DOWN k=2: pair 5←3.
  - DOWN k=1: pairs 2←1, 4←3, 6←5.
- P_IN[0]=1 is outside the contract. The block computes with the value as given and does not flag it.
- No arithmetic wrap logic. Carry out of column WIDTH appears only on C_OUT.

## Timing
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, S=0, C_OUT=0, working registers=0.
- Reset asserted in any state, including mid-UP or mid-DOWN:
  - Aborts the operation immediately and asynchronously.
  - The in-flight result is discarded and is never presented.
- IN_READY is decoded combinationally from state == IDLE. It is low from the edge after acceptance until the edge after the output handshake.
- IN_VALID outside IDLE is ignored. Operands need not be held after the accept edge.
- Latency: the accept edge is T0. UP occupies edges T1..TL, DOWN edges TL+1..T2L−1, and SUM edge T2L. OUT_VALID is high after T2L.
  - WIDTH=8: 6 cycles.
- Throughput, with OUT_READY held high: one result per 2L+2 cycles.
- OUT_VALID&OUT_READY in DONE → IDLE at that edge. A new operand can be accepted on the following edge, not the same one.

## Structure
- Package brent_kung_pkg:
  - state enum {IDLE, UP, DOWN, SUM, DONE}.
  - Level-counter width function clog2.
  - pg_combine function on {G,P} pairs.
- Sub-module pg_black_cell: the combinational combine operator. Instantiated WIDTH/2 times and muxed per level, or unrolled per index with level enables.
- Single always_ff for state, k and the working registers. Output registers are written only in SUM and on reset.

## Test plan
- Vectors are driven as P=A^B, G=A&B per column, column 0 = {0, C_0}, WIDTH=8.
- A=0xFF, B=0x01, C_0=0 → S=0x00, C_OUT=1. OUT_VALID rises exactly 6 cycles after accept.
- A=0x00, B=0x00, C_0=1 → S=0x01, C_OUT=0. A=0xFF, B=0x00, C_0=1 → S=0x00, C_OUT=1.
- A=0x5A, B=0x3C, C_0=0 → S=0x96, C_OUT=0. IN_VALID held high continuously, with a new operand ready → second accept occurs 1 cycle after the output handshake.
- Backpressure: OUT_READY=0 for 5 cycles in DONE → S/C_OUT/OUT_VALID stable and IN_READY=0 throughout, then one handshake.
- RST pulsed at UP k=2 → all outputs reach reset values without a clock. Next operand A=0x80, B=0x80, C_0=0 → S=0x00, C_OUT=1.
- Random: 10k A/B/C_0 triples with random OUT_READY → {C_OUT,S} == A+B+C_0 on each handshake.
